// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if
// Bundles every non-clock signal of the byte FIFO controller: the input
// byte stream, the output byte stream, occupancy flags and the connection
// to the 16x8 dual-port RAM.
//   slave  : the controller's view (drives in_ready, out_*, count/full/empty,
//            RAM strobes, addresses and write data).
//   master : the environment's view (producer, consumer and RAM).
interface ram_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  ram_write_ready;
  logic                  ram_read_ready;
  logic                  ram_write;
  logic                  ram_read;
  logic [ADDR_WIDTH-1:0] ram_write_addr;
  logic [ADDR_WIDTH-1:0] ram_read_addr;
  logic [DATA_WIDTH-1:0] ram_write_data;
  logic [DATA_WIDTH-1:0] ram_read_data;

  modport slave (
    input  in_data, in_valid, out_ready,
    input  ram_write_ready, ram_read_ready, ram_read_data,
    output in_ready, out_data, out_valid, count, full, empty,
    output ram_write, ram_read, ram_write_addr, ram_read_addr, ram_write_data
  );

  modport master (
    output in_data, in_valid, out_ready,
    output ram_write_ready, ram_read_ready, ram_read_data,
    input  in_ready, out_data, out_valid, count, full, empty,
    input  ram_write, ram_read, ram_write_addr, ram_read_addr, ram_write_data
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// Byte-stream FIFO controller wrapped around an external dual-port RAM.
// Accepted input bytes are written straight into the RAM (combinational
// write strobe); a four-state read FSM fetches bytes back one at a time
// and presents them on a registered valid/ready output.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : ram_fifo_ctrl_if.slave (streams, occupancy, RAM connection)
module ram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  ram_fifo_ctrl_if.slave      bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  ram_read_q, ram_read_d;
  logic [ADDR_WIDTH-1:0] ram_read_addr_q, ram_read_addr_d;

  logic full, empty, in_ready, wr_fire, read_start, capture;

  assign full       = (count_q == DEPTH);
  assign empty      = (count_q == '0);
  assign in_ready   = bus.ram_write_ready & ~full;
  assign wr_fire    = bus.in_valid & in_ready;
  assign read_start = (state_q == IDLE) & ~empty & bus.ram_read_ready;
  assign capture    = (state_q == WAIT) & bus.ram_read_ready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      out_data_q      <= '0;
      out_valid_q     <= 1'b0;
      ram_read_q      <= 1'b0;
      ram_read_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      out_data_q      <= out_data_d;
      out_valid_q     <= out_valid_d;
      ram_read_q      <= ram_read_d;
      ram_read_addr_q <= ram_read_addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (read_start) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.ram_read_ready) state_d = HOLD;
      HOLD:    if (out_valid_q & bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    wr_ptr_d        = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d        = (state_q == ISSUE) ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ram_read_d      = read_start;
    ram_read_addr_d = read_start ? rd_ptr_q : ram_read_addr_q;
    out_data_d      = out_data_q;
    out_valid_d     = out_valid_q;
    count_d         = count_q;

    if (capture) begin
      out_data_d  = bus.ram_read_data;
      out_valid_d = 1'b1;
    end else if ((state_q == HOLD) & out_valid_q & bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // The RAM slot is released only at capture, so a write that wraps onto
    // the slot being fetched is blocked by full until the byte is safe.
    case ({wr_fire, capture})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign bus.in_ready       = in_ready;
  assign bus.full           = full;
  assign bus.empty          = empty;
  assign bus.count          = count_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.ram_write      = wr_fire;
  assign bus.ram_write_addr = wr_ptr_q;
  assign bus.ram_write_data = bus.in_data;
  assign bus.ram_read       = ram_read_q;
  assign bus.ram_read_addr  = ram_read_addr_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl
// Bench for ram_fifo_ctrl with a behavioural 16x8 RAM whose read latency is
// adjustable. Accepted bytes are queued as expected output and compared in
// order when the consumer takes them.
module tb_ram_fifo_ctrl;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ram_fifo_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  ram_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural RAM: ReadReady drops for ram_lat cycles after a read strobe.
  logic [7:0] mem [16];
  logic [7:0] rdata = 8'h00;
  int         busy = 0;
  int         ram_lat = 0;
  logic       rd_block = 1'b0;
  logic       wr_rdy = 1'b1;

  always @(posedge clock) begin
    if (bus.ram_write) mem[bus.ram_write_addr] <= bus.ram_write_data;
    if (bus.ram_read) begin
      rdata <= mem[bus.ram_read_addr];
      busy  <= ram_lat;
    end else if (busy != 0) begin
      busy <= busy - 1;
    end
  end

  assign bus.ram_read_ready  = (busy == 0) && !rd_block;
  assign bus.ram_read_data   = rdata;
  assign bus.ram_write_ready = wr_rdy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and per-cycle invariants, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
    end else begin
      check("ram_write_strobe", bus.ram_write, bus.in_valid && wr_rdy && (bus.count != 5'd16));
      check("in_ready_rule", bus.in_ready, wr_rdy && (bus.count != 5'd16));
      check("full_flag", bus.full, bus.count == 5'd16);
      check("empty_flag", bus.empty, bus.count == 5'd0);
      check("count_bound", bus.count <= 5'd16, 1);
      if (bus.ram_write) check("write_data", bus.ram_write_data, bus.in_data);
      if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("pop_nonempty", 0, 1);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          $display("out byte 0x%02h (expected 0x%02h)", bus.out_data, e);
          check("sb_data", bus.out_data, e);
        end
      end
    end
  end

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("push_accept", bus.in_ready, 1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(bus.count == 0 && !bus.out_valid) && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_done", (bus.count == 0) && !bus.out_valid, 1);
    check("drain_empty", bus.empty, 1);
  endtask

  typedef struct {
    logic [7:0] din;
    int         lat;
    int         exp_lat;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;

    vecs[0] = '{8'h11, 0, 3, 8'h11};
    vecs[1] = '{8'h22, 0, 3, 8'h22};
    vecs[2] = '{8'h5A, 5, 8, 8'h5A};
    vecs[3] = '{8'hC3, 2, 5, 8'hC3};
    vecs[4] = '{8'hFF, 1, 4, 8'hFF};
    vecs[5] = '{8'h00, 0, 3, 8'h00};
    vecs[6] = '{8'h96, 7, 10, 8'h96};

    reset         = 1'b1;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_ram_read", bus.ram_read, 0);
    check("rst_read_addr", bus.ram_read_addr, 0);
    check("rst_write_addr", bus.ram_write_addr, 0);
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // Three back-to-back bytes, first out_valid exactly 3 cycles after accept.
    bus.out_ready = 1'b1;
    push(8'h11);
    bus.in_data = 8'h22; bus.in_valid = 1'b1;
    @(posedge clock); #1;
    check("b2b_valid_e1", bus.out_valid, 0);
    bus.in_data = 8'h33;
    @(posedge clock); #1;
    check("b2b_valid_e2", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    check("b2b_valid_e3", bus.out_valid, 1);
    check("b2b_data_e3", bus.out_data, 8'h11);
    wait_drain();

    // Table: single byte with varying RAM read latency.
    for (int i = 0; i < 7; i++) begin
      ram_lat = vecs[i].lat;
      push(vecs[i].din);
      n = 0;
      while (!bus.out_valid && n < 50) begin
        @(posedge clock); #1;
        n++;
      end
      check($sformatf("vec%0d_latency", i), n, vecs[i].exp_lat);
      check($sformatf("vec%0d_data", i), bus.out_data, vecs[i].exp_out);
      wait_drain();
    end
    ram_lat = 0;

    // Fill to 16 with reads blocked, 17th byte held off until one is consumed.
    bus.out_ready = 1'b0;
    rd_block = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    check("fill_count", bus.count, 16);
    check("fill_full", bus.full, 1);
    check("fill_in_ready", bus.in_ready, 0);
    bus.in_data = 8'h10; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("held_in_ready", bus.in_ready, 0);
      check("held_count", bus.count, 16);
    end
    rd_block = 1'b0;
    bus.out_ready = 1'b1;
    push(8'h10);
    wait_drain();

    // Refill across the pointer wrap while draining.
    for (int i = 0; i < 20; i++) push(8'h80 + 8'(i));
    wait_drain();

    // Write and capture on the same edge with count = 5.
    bus.out_ready = 1'b0;
    ram_lat = 8;
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
    n = 0;
    while (!bus.ram_read_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("sim_pre_count", bus.count, 5);
    check("sim_pre_valid", bus.out_valid, 0);
    bus.in_data = 8'hA5; bus.in_valid = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    check("sim_post_count", bus.count, 5);
    check("sim_post_valid", bus.out_valid, 1);
    check("sim_post_data", bus.out_data, 8'h40);
    ram_lat = 0;
    bus.out_ready = 1'b1;
    wait_drain();

    // Reset while waiting on a slow read with count = 3.
    bus.out_ready = 1'b0;
    ram_lat = 5;
    push(8'hE1); push(8'hE2); push(8'hE3);
    check("rw_pre_count", bus.count, 3);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rw_count", bus.count, 0);
    check("rw_out_valid", bus.out_valid, 0);
    check("rw_empty", bus.empty, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      check("rw_no_stale_valid", bus.out_valid, 0);
      check("rw_no_read", bus.ram_read, 0);
    end
    ram_lat = 0;

    // Post-reset traffic starts from slot 0 again.
    push(8'h77);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("rw_after_data", bus.out_data, 8'h77);
    wait_drain();

    check("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
